// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator command sequencer and the 6-bit ALU it drives:
// default widths, opcode encoding, sequencer state encoding.
package alu_pkg;

    localparam int W_DEF   = 6;
    localparam int OPW_DEF = 4;

    localparam logic [OPW_DEF-1:0] OP_NEG  = 4'b0000;
    localparam logic [OPW_DEF-1:0] OP_LOAD = 4'b0001;
    localparam logic [OPW_DEF-1:0] OP_EQ   = 4'b0010;
    localparam logic [OPW_DEF-1:0] OP_DIFF = 4'b0011;
    localparam logic [OPW_DEF-1:0] OP_MORE = 4'b0100;
    localparam logic [OPW_DEF-1:0] OP_MOE  = 4'b0101;
    localparam logic [OPW_DEF-1:0] OP_LESS = 4'b0110;
    localparam logic [OPW_DEF-1:0] OP_LOE  = 4'b0111;
    localparam logic [OPW_DEF-1:0] OP_INC  = 4'b1000;
    localparam logic [OPW_DEF-1:0] OP_DEC  = 4'b1001;
    localparam logic [OPW_DEF-1:0] OP_ADD  = 4'b1010;
    localparam logic [OPW_DEF-1:0] OP_SUB  = 4'b1011;
    localparam logic [OPW_DEF-1:0] OP_NAND = 4'b1100;
    localparam logic [OPW_DEF-1:0] OP_XOR  = 4'b1101;
    localparam logic [OPW_DEF-1:0] OP_AND  = 4'b1110;
    localparam logic [OPW_DEF-1:0] OP_OR   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Compare ops report only through the result port; they never touch the accumulator.
    function automatic logic is_compare(input logic [OPW_DEF-1:0] op);
        return (op >= OP_EQ) && (op <= OP_LOE);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Show-ahead synchronous FIFO holding packed {op, operand} commands.
// Head entry is visible on o_rdata whenever o_empty is low.
module alu_cmd_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_wdata,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only honoured when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-based command sequencer: queues {op, operand}, drives the ALU with
// x = acc / y = operand, captures z and flags, and returns results over valid/ready.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int OPW       = OPW_DEF,
    parameter int CMD_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [OPW-1:0]              cmd_op,
    input  logic [W-1:0]                cmd_operand,
    output logic [W-1:0]                alu_x,
    output logic [W-1:0]                alu_y,
    output logic [OPW-1:0]              alu_op,
    input  logic [W-1:0]                alu_z,
    input  logic                        alu_iof,
    input  logic                        alu_baf,
    input  logic                        alu_zf,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [W-1:0]                res_data,
    output logic                        res_iof,
    output logic                        res_baf,
    output logic                        res_zf,
    output logic [W-1:0]                acc,
    output logic                        busy,
    output logic [$clog2(CMD_DEPTH):0]  fifo_count
);
    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_acc, w_acc_nxt;
    logic [W-1:0]   r_alu_x, w_alu_x_nxt;
    logic [W-1:0]   r_alu_y, w_alu_y_nxt;
    logic [OPW-1:0] r_alu_op, w_alu_op_nxt;
    logic [W-1:0]   r_res_data, w_res_data_nxt;
    logic           r_res_valid, w_res_valid_nxt;
    logic           r_res_iof, w_res_iof_nxt;
    logic           r_res_baf, w_res_baf_nxt;
    logic           r_res_zf, w_res_zf_nxt;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_full;
    logic                 w_empty;
    logic [W+OPW-1:0]     w_head;
    logic [OPW-1:0]       w_head_op;
    logic [W-1:0]         w_head_opnd;

    assign cmd_ready   = !w_full;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_head_op   = w_head[W+OPW-1:W];
    assign w_head_opnd = w_head[W-1:0];

    alu_cmd_fifo #(
        .DW    (W + OPW),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({cmd_op, cmd_operand}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_alu_x_nxt     = r_alu_x;
        w_alu_y_nxt     = r_alu_y;
        w_alu_op_nxt    = r_alu_op;
        w_res_data_nxt  = r_res_data;
        w_res_valid_nxt = r_res_valid;
        w_res_iof_nxt   = r_res_iof;
        w_res_baf_nxt   = r_res_baf;
        w_res_zf_nxt    = r_res_zf;
        w_issue         = 1'b0;

        case (r_state)
            ST_IDLE: w_issue = !w_empty;
            ST_EXEC: begin
                w_res_data_nxt  = alu_z;
                w_res_iof_nxt   = alu_iof;
                w_res_baf_nxt   = alu_baf;
                w_res_zf_nxt    = alu_zf;
                w_res_valid_nxt = 1'b1;
                if (!is_compare(r_alu_op)) w_acc_nxt = alu_z;
                w_state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    if (!w_empty) begin
                        w_issue = 1'b1;
                    end else begin
                        w_res_valid_nxt = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Issue path is shared by IDLE and the RESP handshake so back-to-back needs no bubble.
        if (w_issue) begin
            if (w_head_op == OP_LOAD) begin
                w_acc_nxt       = w_head_opnd;
                w_res_data_nxt  = w_head_opnd;
                w_res_zf_nxt    = (w_head_opnd == '0);
                w_res_iof_nxt   = 1'b0;
                w_res_baf_nxt   = 1'b0;
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = ST_RESP;
            end else begin
                w_alu_x_nxt     = r_acc;
                w_alu_y_nxt     = w_head_opnd;
                w_alu_op_nxt    = w_head_op;
                w_res_valid_nxt = 1'b0;
                w_state_nxt     = ST_EXEC;
            end
        end
    end

    assign w_pop = w_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_op    <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_iof   <= 1'b0;
            r_res_baf   <= 1'b0;
            r_res_zf    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_alu_x     <= w_alu_x_nxt;
            r_alu_y     <= w_alu_y_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_iof   <= w_res_iof_nxt;
            r_res_baf   <= w_res_baf_nxt;
            r_res_zf    <= w_res_zf_nxt;
        end
    end

    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;
    assign alu_op    = r_alu_op;
    assign acc       = r_acc;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign res_iof   = r_res_iof;
    assign res_baf   = r_res_baf;
    assign res_zf    = r_res_zf;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 6-bit ALU between alu_* ports.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [5:0] cmd_operand = '0;
    logic [5:0] alu_x, alu_y, alu_z;
    logic [3:0] alu_op;
    logic       alu_iof, alu_baf, alu_zf;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_data;
    logic       res_iof, res_baf, res_zf;
    logic [5:0] acc;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;

    logic [3:0] q_op [8];
    logic [5:0] q_opnd [8];
    logic [5:0] got_data [$];
    logic       got_zf [$];
    logic [5:0] got_acc [$];
    int         got_t [$];

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_iof(alu_iof), .alu_baf(alu_baf), .alu_zf(alu_zf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_iof(res_iof), .res_baf(res_baf), .res_zf(res_zf),
        .acc(acc), .busy(busy), .fifo_count(fifo_count)
    );

    // Behavioural ALU: compares give z = 000001 / 000000; baf is carry/borrow out.
    logic [6:0] m_s;
    logic [5:0] m_z;
    logic       m_iof, m_baf;
    always_comb begin
        m_s = '0; m_z = '0; m_iof = 1'b0; m_baf = 1'b0;
        case (alu_op)
            4'b0000: begin m_s = 7'd0 - {1'b0, alu_x}; m_z = m_s[5:0]; m_iof = (alu_x == 6'b100000); end
            4'b0001: m_z = alu_y;
            4'b0010: m_z = {5'b0, alu_x == alu_y};
            4'b0011: m_z = {5'b0, alu_x != alu_y};
            4'b0100: m_z = {5'b0, alu_x >  alu_y};
            4'b0101: m_z = {5'b0, alu_x >= alu_y};
            4'b0110: m_z = {5'b0, alu_x <  alu_y};
            4'b0111: m_z = {5'b0, alu_x <= alu_y};
            4'b1000: begin m_s = {1'b0, alu_x} + 7'd1; m_z = m_s[5:0]; m_baf = m_s[6]; m_iof = (alu_x == 6'b011111); end
            4'b1001: begin m_s = {1'b0, alu_x} - 7'd1; m_z = m_s[5:0]; m_baf = m_s[6]; m_iof = (alu_x == 6'b100000); end
            4'b1010: begin
                m_s = {1'b0, alu_x} + {1'b0, alu_y}; m_z = m_s[5:0]; m_baf = m_s[6];
                m_iof = (alu_x[5] == alu_y[5]) && (m_z[5] != alu_x[5]);
            end
            4'b1011: begin
                m_s = {1'b0, alu_x} - {1'b0, alu_y}; m_z = m_s[5:0]; m_baf = m_s[6];
                m_iof = (alu_x[5] != alu_y[5]) && (m_z[5] != alu_x[5]);
            end
            4'b1100: m_z = ~(alu_x & alu_y);
            4'b1101: m_z = alu_x ^ alu_y;
            4'b1110: m_z = alu_x & alu_y;
            default: m_z = alu_x | alu_y;
        endcase
    end
    assign alu_z   = m_z;
    assign alu_iof = m_iof;
    assign alu_baf = m_baf;
    assign alu_zf  = (m_z == '0);

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [5:0] opnd);
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 20) begin tick(); cyc++; end
    endtask

    // Streams q_op/q_opnd[0..n-1] one per cycle and records every result seen with its cycle.
    task automatic run_seq(input int n);
        got_data.delete(); got_zf.delete(); got_acc.delete(); got_t.delete();
        for (int c = 0; c < 25; c++) begin
            if (c < n) begin
                cmd_valid = 1'b1; cmd_op = q_op[c]; cmd_operand = q_opnd[c];
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (res_valid) begin
                got_data.push_back(res_data); got_zf.push_back(res_zf);
                got_acc.push_back(acc); got_t.push_back(c);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if ({acc, alu_x, alu_y, alu_op, res_data, res_valid, res_iof, res_baf, res_zf, busy, fifo_count, cmd_ready}
            !== {6'd0, 6'd0, 6'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            bad++; $display("FAIL reset_hold: acc=%b x=%b y=%b op=%b rd=%b rv=%b busy=%b cnt=%0d rdy=%b exp all zero, rdy=1",
                            acc, alu_x, alu_y, alu_op, res_data, res_valid, busy, fifo_count, cmd_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        total++;
        if ({cmd_ready, busy, res_valid, fifo_count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            bad++; $display("FAIL reset_release: rdy=%b busy=%b rv=%b cnt=%0d exp 1 0 0 0", cmd_ready, busy, res_valid, fifo_count);
        end
    endtask

    task automatic test_load_add();
        int cyc;
        res_ready = 1'b1;
        send(4'b0001, 6'b101101);
        wait_res(cyc);
        total++;
        if (cyc !== 1) begin bad++; $display("FAIL load_latency: got %0d exp 1", cyc); end
        total++;
        if ({res_data, res_iof, res_baf, res_zf, acc} !== {6'b101101, 3'b000, 6'b101101}) begin
            bad++; $display("FAIL load_result: data=%b flags=%b%b%b acc=%b exp 101101 000 101101", res_data, res_iof, res_baf, res_zf, acc);
        end
        tick();
        send(4'b1010, 6'b000011);
        wait_res(cyc);
        total++;
        if (cyc !== 2) begin bad++; $display("FAIL add_latency: got %0d exp 2", cyc); end
        total++;
        if ({res_data, res_iof, res_baf, res_zf, acc} !== {6'b110000, 3'b000, 6'b110000}) begin
            bad++; $display("FAIL add_result: data=%b flags=%b%b%b acc=%b exp 110000 000 110000", res_data, res_iof, res_baf, res_zf, acc);
        end
        total++;
        if ({alu_x, alu_y, alu_op} !== {6'b101101, 6'b000011, 4'b1010}) begin
            bad++; $display("FAIL add_alu_regs: x=%b y=%b op=%b exp 101101 000011 1010", alu_x, alu_y, alu_op);
        end
        tick();
        total++;
        if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL add_drain: rv=%b busy=%b exp 0 0", res_valid, busy); end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        q_op[0] = 4'b0001; q_opnd[0] = 6'b010101;
        q_op[1] = 4'b1000; q_opnd[1] = 6'b000000;
        q_op[2] = 4'b1001; q_opnd[2] = 6'b000000;
        run_seq(3);
        total++;
        if (got_data.size() !== 3) begin bad++; $display("FAIL incdec_count: got %0d exp 3", got_data.size()); end
        else begin
            total++;
            if ({got_data[0], got_data[1], got_data[2]} !== {6'b010101, 6'b010110, 6'b010101}) begin
                bad++; $display("FAIL incdec_data: got %b %b %b exp 010101 010110 010101", got_data[0], got_data[1], got_data[2]);
            end
            total++;
            if (got_t[2] - got_t[1] !== 2) begin bad++; $display("FAIL incdec_spacing: got %0d exp 2", got_t[2] - got_t[1]); end
        end
        total++;
        if (acc !== 6'b010101) begin bad++; $display("FAIL incdec_acc: got %b exp 010101", acc); end
    endtask

    task automatic test_compare();
        res_ready = 1'b1;
        q_op[0] = 4'b0001; q_opnd[0] = 6'b010101;
        q_op[1] = 4'b0010; q_opnd[1] = 6'b010101;
        q_op[2] = 4'b0010; q_opnd[2] = 6'b010111;
        run_seq(3);
        total++;
        if (got_data.size() !== 3) begin bad++; $display("FAIL cmp_count: got %0d exp 3", got_data.size()); end
        else begin
            total++;
            if ({got_data[0], got_data[1], got_data[2]} !== {6'b010101, 6'b000001, 6'b000000}) begin
                bad++; $display("FAIL cmp_data: got %b %b %b exp 010101 000001 000000", got_data[0], got_data[1], got_data[2]);
            end
            total++;
            if ({got_zf[0], got_zf[1], got_zf[2]} !== 3'b001) begin
                bad++; $display("FAIL cmp_zf: got %b%b%b exp 001", got_zf[0], got_zf[1], got_zf[2]);
            end
            total++;
            if ({got_acc[0], got_acc[1], got_acc[2]} !== {3{6'b010101}}) begin
                bad++; $display("FAIL cmp_acc: got %b %b %b exp 010101 x3", got_acc[0], got_acc[1], got_acc[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_op = (i == 0) ? 4'b0001 : 4'b1000;
            cmd_operand = (i == 0) ? 6'b000001 : 6'b000000;
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        total++;
        if (accepted !== 5) begin bad++; $display("FAIL bp_accepted: got %0d exp 5", accepted); end
        total++;
        if ({cmd_ready, fifo_count, busy} !== {1'b0, 3'd4, 1'b1}) begin
            bad++; $display("FAIL bp_full: rdy=%b cnt=%0d busy=%b exp 0 4 1", cmd_ready, fifo_count, busy);
        end
        repeat (3) tick();
        total++;
        if ({res_valid, res_data, res_iof, res_baf, res_zf, fifo_count} !== {1'b1, 6'b000001, 3'b000, 3'd4}) begin
            bad++; $display("FAIL bp_hold: rv=%b data=%b flags=%b%b%b cnt=%0d exp 1 000001 000 4",
                            res_valid, res_data, res_iof, res_baf, res_zf, fifo_count);
        end
        res_ready = 1'b1;
        run_seq(0);
        total++;
        if (got_data.size() !== 4) begin bad++; $display("FAIL bp_drain_count: got %0d exp 4", got_data.size()); end
        else begin
            total++;
            if ({got_data[0], got_data[1], got_data[2], got_data[3]} !== {6'd2, 6'd3, 6'd4, 6'd5}) begin
                bad++; $display("FAIL bp_drain_order: got %0d %0d %0d %0d exp 2 3 4 5", got_data[0], got_data[1], got_data[2], got_data[3]);
            end
        end
        total++;
        if ({acc, fifo_count, busy} !== {6'b000101, 3'd0, 1'b0}) begin
            bad++; $display("FAIL bp_final: acc=%b cnt=%0d busy=%b exp 000101 0 0", acc, fifo_count, busy);
        end
    endtask

    task automatic test_logic();
        res_ready = 1'b1;
        q_op[0] = 4'b0001; q_opnd[0] = 6'b111000;
        q_op[1] = 4'b1101; q_opnd[1] = 6'b001110;
        q_op[2] = 4'b1111; q_opnd[2] = 6'b001110;
        run_seq(3);
        total++;
        if (got_data.size() !== 3) begin bad++; $display("FAIL logic_count: got %0d exp 3", got_data.size()); end
        else begin
            total++;
            if ({got_data[0], got_data[1], got_data[2]} !== {6'b111000, 6'b110110, 6'b111110}) begin
                bad++; $display("FAIL logic_data: got %b %b %b exp 111000 110110 111110", got_data[0], got_data[1], got_data[2]);
            end
        end
        total++;
        if (acc !== 6'b111110) begin bad++; $display("FAIL logic_acc: got %b exp 111110", acc); end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_op = (i == 0) ? 4'b0001 : 4'b1010;
            cmd_operand = (i == 0) ? 6'b000000 : 6'b000001;
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if ({busy, fifo_count, alu_op, res_valid} !== {1'b1, 3'd3, 4'b1010, 1'b0}) begin
            bad++; $display("FAIL rst_pre: busy=%b cnt=%0d op=%b rv=%b exp 1 3 1010 0", busy, fifo_count, alu_op, res_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({acc, alu_x, alu_y, alu_op, res_data, res_valid, res_iof, res_baf, res_zf, busy, fifo_count, cmd_ready}
            !== {6'd0, 6'd0, 6'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            bad++; $display("FAIL rst_async: acc=%b x=%b y=%b op=%b rd=%b rv=%b busy=%b cnt=%0d rdy=%b exp all zero, rdy=1",
                            acc, alu_x, alu_y, alu_op, res_data, res_valid, busy, fifo_count, cmd_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) hs++;
        end
        total++;
        if ({hs[3:0], fifo_count, acc} !== {4'd0, 3'd0, 6'd0}) begin
            bad++; $display("FAIL rst_after: results=%0d cnt=%0d acc=%b exp 0 0 000000", hs, fifo_count, acc);
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_back_to_back();
        test_compare();
        test_backpressure();
        test_logic();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, exp completion");
        $fatal(1, "watchdog");
    end

endmodule
